slt_seq: RTL and testbench
==========================

Name: slt_seq

Overview:
Multi-cycle magnitude comparator, successor to the single-cycle combinational slt. It compares two N-bit operands W bits per cycle, MSB chunk first, and terminates early on the first differing chunk. Signed or unsigned mode is selected per transaction. It sits between ALU operand registers and branch/flag logic, with valid/ready handshakes on both sides.

Parameters:
N, 32, operand width in bits; must be a multiple of W.
W, 8, chunk width compared per cycle; 1 <= W <= N.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b and is_signed are valid.
in_ready  output  1  block can accept a transaction.
a  input  N  operand A.
b  input  N  operand B.
is_signed  input  1  1 = two's-complement compare; 0 = unsigned compare.
out_valid  output  1  lt/eq/gt hold a valid result.
out_ready  input  1  consumer accepts the result.
lt  output  1  a < b.
eq  output  1  a == b.
gt  output  1  a > b.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, lt=eq=gt=0, chunk counter=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE); registered or decoded from state, never combinational from in_valid.
- IDLE:
  - On in_valid & in_ready: capture a and b into shift registers.
  - If is_signed=1, invert bit N-1 of both captured values. This maps signed order onto unsigned order.
  - Clear counter; go to RUN.
  - in_valid without in_ready has no effect.
- RUN, each cycle: compare the top W bits of the A and B registers, unsigned.
  - Chunk A > chunk B: latch gt=1, lt=eq=0; go to DONE.
  - Chunk A < chunk B: latch lt=1, gt=eq=0; go to DONE.
  - Chunks equal and counter == N/W-1: latch eq=1; go to DONE.
  - Chunks equal otherwise: shift both registers left by W; counter++.
- Latency: k cycles from the accepting edge to out_valid=1, where k = 1-based index (from MSB) of the first differing chunk. k = N/W when the operands are equal.
- DONE:
  - out_valid=1; exactly one of lt/eq/gt is 1.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: out_valid drops and lt/eq/gt clear to 0 on the next edge; go to IDLE.
  - No new transaction is accepted until IDLE; minimum issue interval is k+2 cycles.
- is_signed is sampled only at acceptance; later changes are ignored.
- a and b may change freely after acceptance.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the in-flight result is discarded.
- Counter width: $clog2(N/W) bits, minimum 1.
- W == N degenerates to a 1-cycle compare. It must work with no zero-width vectors.
- No X propagation: all outputs are driven from flops at all times after reset.

Test Plan:
1. N=32, W=8, a=0, b=0, is_signed=0 -> eq=1, lt=gt=0, out_valid rises 4 cycles after acceptance.
2. a=32'hFFFFFFFF (-1), b=1: is_signed=1 -> lt=1, latency 1. Repeat with is_signed=0 -> gt=1, latency 1.
3. a=32'h7FFFFFFF, b=32'h80000000: is_signed=1 -> gt=1. is_signed=0 -> lt=1. Both latency 1 (overflow/sign-boundary case).
4. a=32'h12345600, b=32'h12345601, unsigned -> lt=1 at latency 4. a=32'h12FF0000, b=32'h12000000 -> gt=1 at latency 2.
5. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and outputs stable, in_ready=0. Toggling in_valid with new operands is ignored. out_ready=1 -> IDLE next edge, in_ready=1.
6. Random plus reset:
   - 200 random signed/unsigned transactions with random out_ready stalls, checked against a behavioural `<`/`==` model using the === checker.
   - Pulse rst_n low mid-RUN -> outputs 0 and in_ready=1 immediately; the next transaction completes correctly.
   - Re-run the suite with W=1 and W=N.

Source files
------------

// File: rtl/slt_seq.sv
// Multi-cycle magnitude comparator: walks the operands W bits per cycle from the MSB
// and stops on the first differing chunk. Signed mode flips the sign bits at capture.
module slt_seq #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  localparam int unsigned NCH = N / W;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  a_sh, b_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [W-1:0]  chunk_a, chunk_b;

  assign chunk_a = a_q[N-1 -: W];
  assign chunk_b = b_q[N-1 -: W];

  // Single-chunk operands never shift, which avoids a zero-width slice when W == N.
  generate
    if (NCH > 1) begin : g_shift
      assign a_sh = {a_q[N-W-1:0], {W{1'b0}}};
      assign b_sh = {b_q[N-W-1:0], {W{1'b0}}};
    end else begin : g_noshift
      assign a_sh = a_q;
      assign b_sh = b_q;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d        = a;
          b_d        = b;
          a_d[N-1]   = a[N-1] ^ is_signed;
          b_d[N-1]   = b[N-1] ^ is_signed;
          cnt_d      = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (chunk_a > chunk_b) begin
          gt_d        = 1'b1;
          lt_d        = 1'b0;
          eq_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (chunk_a < chunk_b) begin
          lt_d        = 1'b1;
          gt_d        = 1'b0;
          eq_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (cnt_q == CW'(NCH - 1)) begin
          eq_d        = 1'b1;
          lt_d        = 1'b0;
          gt_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          a_d   = a_sh;
          b_d   = b_sh;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          lt_d        = 1'b0;
          eq_d        = 1'b0;
          gt_d        = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        lt_d        = 1'b0;
        eq_d        = 1'b0;
        gt_d        = 1'b0;
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;

endmodule

// File: tb/tb_slt_seq.sv
// Bench for slt_seq: three instances (W=8, W=1, W=32) sharing operands, driven one
// at a time through a directed vector table, back-pressure, reset and random sequences.
module tb_slt_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        is_signed;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        lt [3];
  logic        eq [3];
  logic        gt [3];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
    slt_seq #(.N(32), .W(WS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .lt        (lt[g]),
      .eq        (eq[g]),
      .gt        (gt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic        lt;
    logic        eq;
    logic        gt;
    int          lat;
  } vec_t;

  vec_t vt [10];

  function automatic int w_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 1 : 32);
  endfunction

  // Latency = 1-based index of the first chunk holding a differing bit.
  function automatic int lat_of(input int w, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] x;
    x = av ^ bv;
    for (int i = 31; i >= 0; i--)
      if (x[i]) return (31 - i) / w + 1;
    return 32 / w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic txn(input int d, input logic [31:0] av, input logic [31:0] bv, input logic sg,
                     input logic elt, input logic eeq, input logic egt, input int elat,
                     input int stall, input string nm);
    int cyc;
    chk({nm, ".in_ready_pre"}, 32'(in_ready[d]), 32'd1);
    a = av; b = bv; is_signed = sg; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a = $urandom; b = $urandom; is_signed = ~sg;
    cyc = 0;
    while (!out_valid[d] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, ".latency"}, 32'(cyc), 32'(elat));
    chk({nm, ".out_valid"}, 32'(out_valid[d]), 32'd1);
    chk({nm, ".lt"}, 32'(lt[d]), 32'(elt));
    chk({nm, ".eq"}, 32'(eq[d]), 32'(eeq));
    chk({nm, ".gt"}, 32'(gt[d]), 32'(egt));
    for (int s = 0; s < stall; s++) begin
      in_valid[d] = s[0];
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk({nm, ".stall_flags"}, {28'd0, out_valid[d], lt[d], eq[d], gt[d]},
          {28'd0, 1'b1, elt, eeq, egt});
      chk({nm, ".stall_in_ready"}, 32'(in_ready[d]), 32'd0);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    chk({nm, ".release_flags"}, {28'd0, out_valid[d], lt[d], eq[d], gt[d]}, 32'd0);
    chk({nm, ".release_in_ready"}, 32'(in_ready[d]), 32'd1);
  endtask

  task automatic model_txn(input int d, input logic [31:0] av, input logic [31:0] bv,
                           input logic sg, input int stall, input string nm);
    logic elt, eeq, egt;
    elt = sg ? ($signed(av) < $signed(bv)) : (av < bv);
    egt = sg ? ($signed(av) > $signed(bv)) : (av > bv);
    eeq = (av == bv);
    txn(d, av, bv, sg, elt, eeq, egt, lat_of(w_of(d), av, bv), stall, nm);
  endtask

  initial begin
    // Hand-computed results; latency column is for W=8.
    vt[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
    vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vt[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vt[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vt[5] = '{32'h1234_5600, 32'h1234_5601, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vt[6] = '{32'h12FF_0000, 32'h1200_0000, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vt[8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    vt[9] = '{32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 2};

    rst_n = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset%0d.flags", d), {28'd0, out_valid[d], lt[d], eq[d], gt[d]}, 32'd0);
      chk($sformatf("reset%0d.in_ready", d), 32'(in_ready[d]), 32'd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table on W=8 with the hand latencies; vector 6 also exercises back-pressure.
    for (int i = 0; i < 10; i++)
      txn(0, vt[i].a, vt[i].b, vt[i].sg, vt[i].lt, vt[i].eq, vt[i].gt, vt[i].lat,
          (i == 6) ? 5 : 0, $sformatf("w8_vec%0d", i));

    // Same table on W=1 and W=32: results fixed, latency from chunk position.
    for (int d = 1; d < 3; d++)
      for (int i = 0; i < 10; i++)
        txn(d, vt[i].a, vt[i].b, vt[i].sg, vt[i].lt, vt[i].eq, vt[i].gt,
            lat_of(w_of(d), vt[i].a, vt[i].b), (i == 3) ? 2 : 0,
            $sformatf("w%0d_vec%0d", w_of(d), i));

    // Reset pulse mid-RUN, then a clean transaction.
    a = 32'h0; b = 32'h0; is_signed = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_run.flags", {28'd0, out_valid[0], lt[0], eq[0], gt[0]}, 32'd0);
    chk("rst_run.in_ready", 32'(in_ready[0]), 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 32'h1234_5600, 32'h1234_5601, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0, "after_rst_run");

    // Reset pulse mid-DONE.
    a = 32'h1; b = 32'h0; is_signed = 1'b0; in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(posedge clk); #1;
    chk("rst_done.pre_valid", 32'(out_valid[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_done.flags", {28'd0, out_valid[2], lt[2], eq[2], gt[2]}, 32'd0);
    chk("rst_done.in_ready", 32'(in_ready[2]), 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_txn(2, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, "after_rst_done");

    // Random transactions; every other one shares upper bits to reach deep chunks.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : (ra ^ (32'd1 << $urandom_range(0, 31)));
      if (i % 17 == 0) rb = ra;
      model_txn(i % 3, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
